uart_alu_frame_ctrl: RTL and testbench
======================================

Name: uart_alu_frame_ctrl

Overview:
- Byte-level command controller between the UART receiver/transmitter and the combinational ALU; successor to the fixed 8-bit UART+ALU pairing.
- Assembles multi-byte frames (opcode, operand A, operand B) for parametrised operand width, drives the ALU and captures its result.
- Serialises the result back out as bytes.
- Rejects unsupported opcodes with an error byte.

Parameters:
- NB_DATA, 8, ALU operand/result width; multiple of 8, range 8..32.
- NB_OP, 6, ALU opcode width; must be ≤ 8.
- NB_BYTE, 8, UART byte width.
- ERR_CODE, 8'hEE, byte transmitted in response to an invalid opcode.
- TIMEOUT_CYCLES, 100000, idle clocks before a partial frame is dropped; used only with RX_TIMEOUT_EN.

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  NB_BYTE  received byte; valid when i_rx_done_tick=1
- i_rx_done_tick  in  1  one-cycle strobe per received byte
- o_tx_data  out  NB_BYTE  byte to transmit; held stable from o_tx_start until i_tx_done_tick
- o_tx_start  out  1  one-cycle request to begin transmitting o_tx_data
- i_tx_done_tick  in  1  one-cycle strobe when the transmitter finishes a byte
- o_data_a  out  NB_DATA  registered operand A to the ALU
- o_data_b  out  NB_DATA  registered operand B to the ALU
- o_operation  out  NB_OP  registered opcode to the ALU
- i_result  in  NB_DATA  combinational ALU result
- o_busy  out  1  high whenever state != S_IDLE
- o_error  out  1  one-cycle pulse on invalid opcode or dropped byte

Behaviour:
- Reset (synchronous, i_reset=1 at the clock edge):
  - Drives all outputs to 0 and enters S_IDLE.
  - Clears byte counters and shift registers.
  - Aborts any frame in progress with no further tx_start.
  - Reset has priority over every other event.
- NBY = NB_DATA/8.
- Frame format: 1 opcode byte, then NBY bytes of A, then NBY bytes of B. Operand bytes are LSB first.
- Response: NBY result bytes, LSB first; or the single byte ERR_CODE.
- Valid opcodes (low NB_OP bits; the upper NB_BYTE-NB_OP bits must be 0): ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010. Any other byte is invalid.
- State machine:
  - S_IDLE: on rx tick, latch the byte.
    - Valid opcode: o_operation <= byte[NB_OP-1:0]; go to S_RX_A.
    - Invalid opcode: pulse o_error; go to S_ERR.
  - S_RX_A: each rx tick shifts the byte into the A shift register at position cnt. After the NBY-th byte: o_data_a updates (same edge), cnt <= 0, go to S_RX_B.
  - S_RX_B: same collection for B. On the last byte: o_data_b updates; go to S_EXEC.
  - S_EXEC: one cycle. Capture i_result into the result shift register; go to S_TX_LOAD.
  - S_TX_LOAD: o_tx_data <= current result byte; o_tx_start=1 for exactly this one cycle; go to S_TX_WAIT.
  - S_TX_WAIT: on i_tx_done_tick:
    - if bytes sent < NBY, go to S_TX_LOAD with the next byte;
    - otherwise go to S_IDLE.
  - S_ERR: o_tx_data <= ERR_CODE, o_tx_start pulse, then wait for i_tx_done_tick; go to S_IDLE.
- Latency: rx tick of the last B byte at cycle N → S_EXEC at N+1 → o_tx_start high at N+2.
- o_data_a, o_data_b and o_operation hold their values until overwritten by the next valid frame.
- Bytes received in S_EXEC, S_TX_LOAD, S_TX_WAIT or S_ERR are discarded and produce an o_error pulse. The state is unaffected.
- i_tx_done_tick outside S_TX_WAIT/S_ERR is ignored.
- If i_rx_done_tick and i_tx_done_tick arrive in the same cycle, both are handled per the rules above; tx completion takes effect normally.
- o_tx_start is never asserted while a previously started byte is still awaiting i_tx_done_tick.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined:
  - An idle counter runs in S_RX_A and S_RX_B and is cleared on every rx tick.
  - When it reaches TIMEOUT_CYCLES: pulse o_error, clear the shift registers and counters, and return to S_IDLE.
  - o_data_a, o_data_b and o_operation keep their previous values.
- Not defined: partial frames wait indefinitely; no counter logic is synthesised.

Test Plan:
- NB_DATA=8: send 0x20, 0x05, 0x03; model ALU returns A+B → one o_tx_start with o_tx_data=0x08, two cycles after the last rx tick; o_busy falls after i_tx_done_tick.
- NB_DATA=16: send 0x22, 0x34, 0x12, 0x01, 0x00 (A=0x1234, B=0x0001) → o_data_a=0x1234, o_data_b=0x0001, o_operation=0x22; tx bytes 0x33 then 0x12; second o_tx_start only after the first i_tx_done_tick.
- Send invalid opcode 0x3F → o_error pulse; single tx byte 0xEE; o_operation unchanged from the previous frame.
- Send a byte during S_TX_WAIT → o_error pulse; byte ignored; response completes correctly; the next frame decodes normally.
- Assert i_reset after the opcode and A byte → all outputs 0, state S_IDLE; a following full frame 0x24, 0xF0, 0x3C yields 0x30.
- With RX_TIMEOUT_EN and TIMEOUT_CYCLES=50: send opcode 0x25 only, wait 50 clocks → o_error pulse, return to S_IDLE, no tx; a following frame 0x25, 0x0F, 0xF0 yields 0xFF.

Source files
------------

// File: rtl/uart_alu_frame_ctrl.sv
// uart_alu_frame_ctrl
//
// Byte-level command controller sitting between a UART receiver/transmitter
// pair and a combinational ALU. It assembles a frame of one opcode byte
// followed by NBY bytes of operand A and NBY bytes of operand B (LSB first),
// presents the registered operands and opcode to the ALU, captures the
// result, and sends it back as NBY bytes (LSB first). An unsupported opcode
// is answered with the single byte ERR_CODE.
//
// Optional feature: define the macro RX_TIMEOUT_EN to drop a partial frame
// after TIMEOUT_CYCLES clocks without a received byte. Without the macro,
// partial frames wait indefinitely and no counter logic is built.
//
// Ports:
//   i_clock         system clock
//   i_reset         synchronous, active-high reset
//   i_rx_data       received byte, valid while i_rx_done_tick is high
//   i_rx_done_tick  one-cycle strobe per received byte
//   o_tx_data       byte to transmit, stable from o_tx_start to i_tx_done_tick
//   o_tx_start      one-cycle request to start transmitting o_tx_data
//   i_tx_done_tick  one-cycle strobe when the transmitter finishes a byte
//   o_data_a        registered operand A to the ALU
//   o_data_b        registered operand B to the ALU
//   o_operation     registered opcode to the ALU
//   i_result        combinational ALU result
//   o_busy          high whenever the controller is not idle
//   o_error         one-cycle pulse on invalid opcode, dropped byte or timeout

module uart_alu_frame_ctrl #(
  parameter int                 NB_DATA        = 8,
  parameter int                 NB_OP          = 6,
  parameter int                 NB_BYTE        = 8,
  parameter logic [NB_BYTE-1:0] ERR_CODE       = 8'hEE,
  parameter int                 TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_done_tick,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_operation,
  input  logic [NB_DATA-1:0] i_result,
  output logic               o_busy,
  output logic               o_error
);

  localparam int         NBY      = NB_DATA / NB_BYTE;
  localparam logic [2:0] LAST_IDX = 3'(NBY - 1);

  // Elaboration-time guards on the parameter ranges this controller supports.
  if ((NB_DATA % 8) != 0 || NB_DATA < 8 || NB_DATA > 32) begin : g_bad_nb_data
    $error("NB_DATA must be a multiple of 8 in the range 8..32");
  end
  if (NB_OP > NB_BYTE) begin : g_bad_nb_op
    $error("NB_OP must not exceed the byte width");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // S_ERR_WAIT holds the error byte on the line until the transmitter is done.
  typedef enum logic [2:0] {
    S_IDLE, S_RX_A, S_RX_B, S_EXEC, S_TX_LOAD, S_TX_WAIT, S_ERR, S_ERR_WAIT
  } state_t;

  state_t             state, next_state;
  logic [2:0]         cnt;
  logic [NB_DATA-1:0] operand_sr, operand_ins, result_sr;
  logic               op_valid, cnt_last, rx_discard, timeout;

  // The upper bits above NB_OP must be zero, so compare the whole byte.
  function automatic logic is_valid_op(input logic [NB_BYTE-1:0] b);
    case (b)
      NB_BYTE'(6'b100000), NB_BYTE'(6'b100010), NB_BYTE'(6'b100100),
      NB_BYTE'(6'b100101), NB_BYTE'(6'b100110), NB_BYTE'(6'b100111),
      NB_BYTE'(6'b000011), NB_BYTE'(6'b000010): return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  assign op_valid   = is_valid_op(i_rx_data);
  assign cnt_last   = (cnt == LAST_IDX);
  assign rx_discard = i_rx_done_tick &&
                      (state inside {S_EXEC, S_TX_LOAD, S_TX_WAIT, S_ERR, S_ERR_WAIT});

  // Operand register with the incoming byte dropped into slot cnt, so the
  // final byte can be written straight into o_data_a/o_data_b on its edge.
  always_comb begin
    operand_ins = operand_sr;
    for (int k = 0; k < NBY; k++) begin
      if (cnt == 3'(k)) operand_ins[k*NB_BYTE +: NB_BYTE] = i_rx_data;
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  // Counts clocks without a received byte while a frame is partially collected.
  always_ff @(posedge i_clock) begin
    if (i_reset) idle_cnt <= '0;
    else if ((state == S_RX_A || state == S_RX_B) && !i_rx_done_tick && !timeout)
      idle_cnt <= idle_cnt + 1'b1;
    else idle_cnt <= '0;
  end

  // A byte arriving on the expiry cycle still counts, so it wins over timeout.
  assign timeout = (state == S_RX_A || state == S_RX_B) && !i_rx_done_tick &&
                   (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (i_rx_done_tick) next_state = op_valid ? S_RX_A : S_ERR;
      S_RX_A:     if (timeout) next_state = S_IDLE;
                  else if (i_rx_done_tick && cnt_last) next_state = S_RX_B;
      S_RX_B:     if (timeout) next_state = S_IDLE;
                  else if (i_rx_done_tick && cnt_last) next_state = S_EXEC;
      S_EXEC:     next_state = S_TX_LOAD;
      S_TX_LOAD:  next_state = S_TX_WAIT;
      S_TX_WAIT:  if (i_tx_done_tick) next_state = cnt_last ? S_IDLE : S_TX_LOAD;
      S_ERR:      next_state = S_ERR_WAIT;
      S_ERR_WAIT: if (i_tx_done_tick) next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Moore outputs: a start request is raised only in the two load states,
  // which are always followed by a wait for the transmitter.
  always_comb begin
    o_tx_start = (state == S_TX_LOAD) || (state == S_ERR);
    o_busy     = (state != S_IDLE);
  end

  // Datapath: byte collection, operand/opcode registers, result serialiser.
  // o_tx_data is loaded on the edge entering a load state so it is already
  // valid while o_tx_start is high.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt         <= '0;
      operand_sr  <= '0;
      result_sr   <= '0;
      o_data_a    <= '0;
      o_data_b    <= '0;
      o_operation <= '0;
      o_tx_data   <= '0;
      o_error     <= 1'b0;
    end else begin
      o_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_rx_done_tick) begin
            cnt        <= '0;
            operand_sr <= '0;
            if (op_valid) begin
              o_operation <= i_rx_data[NB_OP-1:0];
            end else begin
              o_error   <= 1'b1;
              o_tx_data <= ERR_CODE;
            end
          end
        end
        S_RX_A, S_RX_B: begin
          if (timeout) begin
            o_error    <= 1'b1;
            cnt        <= '0;
            operand_sr <= '0;
          end else if (i_rx_done_tick) begin
            if (cnt_last) begin
              cnt        <= '0;
              operand_sr <= '0;
              if (state == S_RX_A) o_data_a <= operand_ins;
              else                 o_data_b <= operand_ins;
            end else begin
              cnt        <= cnt + 1'b1;
              operand_sr <= operand_ins;
            end
          end
        end
        S_EXEC: begin
          o_tx_data <= i_result[NB_BYTE-1:0];
          result_sr <= i_result >> NB_BYTE;
          cnt       <= '0;
        end
        S_TX_WAIT: begin
          if (i_tx_done_tick && !cnt_last) begin
            o_tx_data <= result_sr[NB_BYTE-1:0];
            result_sr <= result_sr >> NB_BYTE;
            cnt       <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
      if (rx_discard) o_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// tb_uart_alu_frame_ctrl
//
// Self-checking bench for uart_alu_frame_ctrl. Two instances run side by
// side: index 0 with 8-bit operands and index 1 with 16-bit operands. A
// behavioural ALU answers i_result, and expected response bytes are computed
// from the frame contents sent by the bench. Define RX_TIMEOUT_EN to also
// exercise the partial-frame timeout (built with TIMEOUT_CYCLES=50).

module tb_uart_alu_frame_ctrl;

  localparam int TO_CYCLES = 50;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data;
  logic [1:0] rx_tick, tx_done;

  logic [7:0]  tx_data8, tx_data16, res8;
  logic        tx_start8, tx_start16, busy8, busy16, err8, err16;
  logic [7:0]  da8, db8;
  logic [15:0] da16, db16, res16;
  logic [5:0]  op8, op16;
  logic [31:0] r8w, r16w;

  logic [7:0]  tx_data [2];
  logic [1:0]  tx_start, busy, error;
  logic [31:0] data_a [2];
  logic [31:0] data_b [2];
  logic [5:0]  operation [2];

  int total = 0;
  int bad   = 0;
  logic [5:0] last_op [2];
  logic [7:0] valid_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

  always #5 clock = ~clock;

  uart_alu_frame_ctrl #(.NB_DATA(8), .TIMEOUT_CYCLES(TO_CYCLES)) dut8 (
    .i_clock(clock), .i_reset(reset), .i_rx_data(rx_data), .i_rx_done_tick(rx_tick[0]),
    .o_tx_data(tx_data8), .o_tx_start(tx_start8), .i_tx_done_tick(tx_done[0]),
    .o_data_a(da8), .o_data_b(db8), .o_operation(op8), .i_result(res8),
    .o_busy(busy8), .o_error(err8)
  );

  uart_alu_frame_ctrl #(.NB_DATA(16), .TIMEOUT_CYCLES(TO_CYCLES)) dut16 (
    .i_clock(clock), .i_reset(reset), .i_rx_data(rx_data), .i_rx_done_tick(rx_tick[1]),
    .o_tx_data(tx_data16), .o_tx_start(tx_start16), .i_tx_done_tick(tx_done[1]),
    .o_data_a(da16), .o_data_b(db16), .o_operation(op16), .i_result(res16),
    .o_busy(busy16), .o_error(err16)
  );

  // Reference ALU: plain arithmetic on the operand width w.
  function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
    logic [31:0]        mask, r;
    logic signed [31:0] sa;
    mask = (32'h1 << w) - 32'h1;
    sa   = $signed(a << (32 - w)) >>> (32 - w);
    case (op)
      8'h20:   r = a + b;
      8'h22:   r = a - b;
      8'h24:   r = a & b;
      8'h25:   r = a | b;
      8'h26:   r = a ^ b;
      8'h27:   r = ~(a | b);
      8'h03:   r = sa >>> b;
      8'h02:   r = a >> b;
      default: r = 32'h0;
    endcase
    return r & mask;
  endfunction

  function automatic bit is_valid_model(input logic [7:0] b);
    foreach (valid_ops[i]) if (valid_ops[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Environment ALU driven by the DUT's registered operands.
  always_comb begin
    r8w   = alu_model({2'b00, op8}, 32'(da8), 32'(db8), 8);
    r16w  = alu_model({2'b00, op16}, 32'(da16), 32'(db16), 16);
    res8  = r8w[7:0];
    res16 = r16w[15:0];
    tx_data[0]   = tx_data8;   tx_data[1]   = tx_data16;
    tx_start     = {tx_start16, tx_start8};
    busy         = {busy16, busy8};
    error        = {err16, err8};
    data_a[0]    = 32'(da8);   data_a[1]    = 32'(da16);
    data_b[0]    = 32'(db8);   data_b[1]    = 32'(db16);
    operation[0] = op8;        operation[1] = op16;
  end

  // Drives one byte for one clock; returns on the negedge after it was sampled.
  task automatic send_byte(input int sel, input logic [7:0] b);
    @(negedge clock);
    rx_data      = b;
    rx_tick[sel] = 1'b1;
    @(negedge clock);
    rx_tick[sel] = 1'b0;
  endtask

  // Waits for a start request, checks the byte is held, then acknowledges it.
  task automatic recv_tx(input int sel, output logic [7:0] data, output int waited);
    int d;
    bit held_ok;
    waited = 0;
    while (tx_start[sel] !== 1'b1 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    data = tx_data[sel];
    total++;
    if (tx_start[sel] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL tx_start_seen sel=%0d actual=0 required=1 after %0d cycles", sel, waited);
      return;
    end
    d = $urandom_range(1, 4);
    held_ok = 1'b1;
    for (int i = 0; i < d; i++) begin
      @(negedge clock);
      if (tx_start[sel] !== 1'b0 || tx_data[sel] !== data) held_ok = 1'b0;
    end
    total++;
    if (!held_ok) begin
      bad++;
      $display("[TB] FAIL tx_hold sel=%0d start=%b data=%h required start=0 data=%h",
               sel, tx_start[sel], tx_data[sel], data);
    end
    tx_done[sel] = 1'b1;
    @(negedge clock);
    tx_done[sel] = 1'b0;
  endtask

  // Sends a full frame and checks operands, response bytes, latency and idle.
  task automatic do_frame(input int sel, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    int nby, waited;
    logic [31:0] exp;
    logic [7:0]  got;
    nby = (sel == 0) ? 1 : 2;
    exp = alu_model(op, a, b, 8 * nby);
    send_byte(sel, op);
    for (int i = 0; i < nby; i++) send_byte(sel, a[8*i +: 8]);
    for (int i = 0; i < nby; i++) send_byte(sel, b[8*i +: 8]);
    last_op[sel] = op[5:0];
    total++;
    if (operation[sel] !== op[5:0]) begin
      bad++;
      $display("[TB] FAIL frame_op sel=%0d actual=%h required=%h", sel, operation[sel], op[5:0]);
    end
    total++;
    if (data_a[sel] !== a || data_b[sel] !== b) begin
      bad++;
      $display("[TB] FAIL frame_operands sel=%0d a=%h b=%h required a=%h b=%h",
               sel, data_a[sel], data_b[sel], a, b);
    end
    for (int i = 0; i < nby; i++) begin
      recv_tx(sel, got, waited);
      total++;
      if (got !== exp[8*i +: 8]) begin
        bad++;
        $display("[TB] FAIL result_byte sel=%0d op=%h idx=%0d actual=%h required=%h",
                 sel, op, i, got, exp[8*i +: 8]);
      end
      if (i == 0) begin
        total++;
        if (waited != 1) begin
          bad++;
          $display("[TB] FAIL result_latency sel=%0d actual=%0d required=1", sel, waited);
        end
      end
    end
    total++;
    if (busy[sel] !== 1'b0 || error[sel] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL frame_end_idle sel=%0d busy=%b error=%b required 0/0",
               sel, busy[sel], error[sel]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    last_op[0] = '0;
    last_op[1] = '0;
    for (int s = 0; s < 2; s++) begin
      total++;
      if ({tx_start[s], busy[s], error[s], tx_data[s]} !== 11'h0) begin
        bad++;
        $display("[TB] FAIL reset_ctrl sel=%0d start=%b busy=%b err=%b data=%h required all 0",
                 s, tx_start[s], busy[s], error[s], tx_data[s]);
      end
      total++;
      if (data_a[s] !== 0 || data_b[s] !== 0 || operation[s] !== 0) begin
        bad++;
        $display("[TB] FAIL reset_regs sel=%0d a=%h b=%h op=%h required all 0",
                 s, data_a[s], data_b[s], operation[s]);
      end
    end
  endtask

  task automatic test_add8();
    do_frame(0, 8'h20, 32'h05, 32'h03);
  endtask

  task automatic test_sub16();
    do_frame(1, 8'h22, 32'h1234, 32'h0001);
  endtask

  task automatic test_random_frames();
    logic [31:0] mask;
    for (int s = 0; s < 2; s++) begin
      mask = (s == 0) ? 32'hFF : 32'hFFFF;
      for (int n = 0; n < 8; n++)
        do_frame(s, valid_ops[$urandom_range(0, 7)], $urandom & mask, $urandom & mask);
    end
  endtask

  task automatic test_invalid();
    logic [7:0] got, b;
    int waited;
    send_byte(0, 8'h3F);
    total++;
    if (error[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL invalid_err_pulse actual=%b required=1", error[0]);
    end
    total++;
    if (operation[0] !== last_op[0]) begin
      bad++;
      $display("[TB] FAIL invalid_op_kept actual=%h required=%h", operation[0], last_op[0]);
    end
    recv_tx(0, got, waited);
    total++;
    if (got !== 8'hEE || busy[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL invalid_response byte=%h busy=%b required EE/0", got, busy[0]);
    end
    for (int n = 0; n < 3; n++) begin
      do b = 8'($urandom_range(0, 255)); while (is_valid_model(b));
      send_byte(1, b);
      total++;
      if (error[1] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL invalid16_err byte=%h actual=%b required=1", b, error[1]);
      end
      recv_tx(1, got, waited);
      total++;
      if (got !== 8'hEE || busy[1] !== 1'b0 || operation[1] !== last_op[1]) begin
        bad++;
        $display("[TB] FAIL invalid16_response byte=%h busy=%b op=%h required EE/0/%h",
                 got, busy[1], operation[1], last_op[1]);
      end
    end
  endtask

  task automatic test_rx_during_tx();
    logic [31:0] a, b, exp;
    logic [7:0]  first, got;
    int waited;
    a   = $urandom & 32'hFFFF;
    b   = $urandom & 32'hFFFF;
    exp = alu_model(8'h20, a, b, 16);
    send_byte(1, 8'h20);
    for (int i = 0; i < 2; i++) send_byte(1, a[8*i +: 8]);
    for (int i = 0; i < 2; i++) send_byte(1, b[8*i +: 8]);
    last_op[1] = 6'h20;
    waited = 0;
    while (tx_start[1] !== 1'b1 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    first = tx_data[1];
    total++;
    if (tx_start[1] !== 1'b1 || first !== exp[7:0]) begin
      bad++;
      $display("[TB] FAIL busy_first_byte start=%b data=%h required 1/%h", tx_start[1], first, exp[7:0]);
    end
    send_byte(1, 8'($urandom));
    total++;
    if (error[1] !== 1'b1 || tx_start[1] !== 1'b0 || tx_data[1] !== first) begin
      bad++;
      $display("[TB] FAIL busy_rx_discard err=%b start=%b data=%h required 1/0/%h",
               error[1], tx_start[1], tx_data[1], first);
    end
    tx_done[1] = 1'b1;
    @(negedge clock);
    tx_done[1] = 1'b0;
    recv_tx(1, got, waited);
    total++;
    if (got !== exp[15:8] || busy[1] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL busy_second_byte data=%h busy=%b required %h/0", got, busy[1], exp[15:8]);
    end
    do_frame(1, valid_ops[$urandom_range(0, 7)], $urandom & 32'hFFFF, $urandom & 32'hFFFF);
  endtask

  task automatic test_reset_mid_frame();
    send_byte(0, 8'h24);
    send_byte(0, 8'hF0);
    total++;
    if (data_a[0] !== 32'hF0 || busy[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midframe_a a=%h busy=%b required F0/1", data_a[0], busy[0]);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    last_op[0] = '0;
    last_op[1] = '0;
    total++;
    if ({busy[0], tx_start[0], error[0], tx_data[0]} !== 11'h0 ||
        data_a[0] !== 0 || operation[0] !== 0) begin
      bad++;
      $display("[TB] FAIL midframe_reset busy=%b start=%b err=%b data=%h a=%h op=%h required all 0",
               busy[0], tx_start[0], error[0], tx_data[0], data_a[0], operation[0]);
    end
    do_frame(0, 8'h24, 32'hF0, 32'h3C);
  endtask

`ifdef RX_TIMEOUT_EN
  task automatic test_timeout();
    send_byte(0, 8'h25);
    repeat (TO_CYCLES - 1) @(negedge clock);
    total++;
    if (error[0] !== 1'b0 || busy[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL timeout_early err=%b busy=%b required 0/1", error[0], busy[0]);
    end
    @(negedge clock);
    total++;
    if (error[0] !== 1'b1 || busy[0] !== 1'b0 || tx_start[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_fire err=%b busy=%b start=%b required 1/0/0",
               error[0], busy[0], tx_start[0]);
    end
    do_frame(0, 8'h25, 32'h0F, 32'hF0);
  endtask
`endif

  initial begin
    rx_data = '0;
    rx_tick = '0;
    tx_done = '0;
    test_reset();
    test_add8();
    test_sub16();
    test_random_frames();
    test_invalid();
    test_rx_during_tx();
    test_reset_mid_frame();
`ifdef RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
